// File: rtl/fetch_stage.sv
// fetch_stage
// -----------
// Instruction-fetch stage. Owns the program counter, issues word requests to
// instruction memory over a req/gnt/rvalid handshake, and buffers returned
// words together with their PC in a small in-order FIFO that decode drains
// under stall_i. A redirect (flush_i) empties the buffer, restarts fetching at
// the new PC and drops every response that was already in flight.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   stall_i         decode cannot accept the head instruction this cycle
//   flush_i         redirect request, redirect_pc_i[1:0] are ignored
//   redirect_pc_i   new fetch PC
//   imem_req_o      fetch request valid (never depends on imem_gnt_i)
//   imem_addr_o     word-aligned fetch address, held until granted
//   imem_gnt_i      memory accepts the request this cycle
//   imem_rvalid_i   in-order response valid
//   imem_rdata_i    response instruction word
//   instruction_o   head instruction, or NOP (addi x0,x0,0) when empty
//   pc_o            PC of head instruction, 0 when empty
//   valid_o         buffer non-empty
module fetch_stage #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FIFO_DEPTH    = 4,
    parameter type         instruction_t = logic [31:0]
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    output instruction_t instruction_o,
    output logic [31:0]  pc_o,
    output logic         valid_o
);

    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam instruction_t   NOP     = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    instruction_t     fifo_instr [FIFO_DEPTH];

    logic [31:0]      redirect_pc;
    logic [CNT_W:0]   credit_used;
    logic             req_fire;
    logic             push;
    logic             pop;

    assign redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;

    // A request is only issued when a buffer slot is guaranteed for its
    // response: every in-flight request plus every buffered word holds one
    // slot. A pop in the same cycle is not counted, which keeps imem_req_o
    // independent of stall_i and of the memory side.
    assign credit_used = {1'b0, outstanding} + {1'b0, count};
    assign imem_req_o  = !rst && !flush_i && (credit_used < DEPTH_C);
    assign imem_addr_o = fetch_pc;
    assign req_fire    = imem_req_o && imem_gnt_i;

    // A redirect voids any same-cycle push or pop.
    assign push = imem_rvalid_i && (discard == '0) && !flush_i;
    assign pop  = valid_o && !stall_i && !flush_i;

    // Decode-side outputs come only from buffer registers.
    assign valid_o       = (count != '0);
    assign instruction_o = valid_o ? fifo_instr[rd_ptr] : NOP;
    assign pc_o          = valid_o ? fifo_pc[rd_ptr] : 32'h0;

    // Request PC advances on each grant; response PC tracks the PC of the
    // next word that will actually be kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (flush_i) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    // outstanding counts every granted-but-unanswered request, including
    // ones whose responses will be dropped, so on a redirect all of them
    // become stale. The response arriving in the redirect cycle is dropped
    // here directly and so is not added to discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            case ({req_fire, imem_rvalid_i})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (flush_i) begin
                discard <= imem_rvalid_i ? (outstanding - CNT_W'(1)) : outstanding;
            end else if (imem_rvalid_i && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
        end
    end

    // Buffer pointers and occupancy; pointers wrap naturally because the
    // depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer storage needs no reset: entries are only read while count != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= instruction_t'(imem_rdata_i);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
// --------------
// Directed bench for fetch_stage. A small memory model answers granted
// requests in order after a configurable latency with the word ~addr, so
// every expected instruction is simply the bitwise inverse of its PC.
// Inputs change 1 time unit after the rising edge; outputs are checked on
// the falling edge. Cycle 1 of each scenario is the first cycle with rst=0.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0080;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;

    int tests_run    = 0;
    int tests_failed = 0;
    int mem_lat      = 1;
    int edge_cnt     = 0;
    logic [31:0] addr_q[$];
    int          due_q[$];

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    // In-order memory: a request granted in cycle N is answered in cycle
    // N + mem_lat. Reset clears everything in flight.
    always @(posedge clk) begin
        if (rst) begin
            addr_q.delete();
            due_q.delete();
            imem_rvalid_i <= 1'b0;
            imem_rdata_i  <= 32'h0;
        end else begin
            if (imem_req_o && imem_gnt_i) begin
                addr_q.push_back(imem_addr_o);
                due_q.push_back(edge_cnt + mem_lat - 1);
            end
            if (due_q.size() > 0 && due_q[0] <= edge_cnt) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= ~addr_q[0];
                void'(addr_q.pop_front());
                void'(due_q.pop_front());
            end else begin
                imem_rvalid_i <= 1'b0;
            end
        end
        edge_cnt <= edge_cnt + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle_begin();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 1 with idle inputs.
    task automatic do_reset();
        rst           = 1'b1;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b1;
        cycle_begin();
        cycle_begin();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b1;
        cycle_begin();
        cycle_begin();
        @(negedge clk);
        tests_run++;
        if (valid_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b expected 0", valid_o);
        end
        tests_run++;
        if (instruction_o !== NOP) begin
            tests_failed++;
            $display("[TB] FAIL reset_instr: got %h expected %h", instruction_o, NOP);
        end
        tests_run++;
        if (pc_o !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_pc: got %h expected 0", pc_o);
        end
        tests_run++;
        if (imem_req_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_req: got %b expected 0", imem_req_o);
        end
        cycle_begin();
    endtask

    // Zero-wait memory: request in cycle 1, first valid in cycle 3, then one
    // instruction per cycle with no gaps.
    task automatic test_stream();
        logic [31:0] exp_pc;
        mem_lat = 1;
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tests_run++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, RST_PC}) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=%h",
                             imem_req_o, imem_addr_o, RST_PC);
                end
            end else if (c == 2) begin
                tests_run++;
                if (valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_latency c2: got valid=%b expected 0", valid_o);
                end
            end else begin
                exp_pc = RST_PC + 32'(4 * (c - 3));
                tests_run++;
                if ({valid_o, pc_o, instruction_o} !== {1'b1, exp_pc, ~exp_pc}) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_head c%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                             c, valid_o, pc_o, instruction_o, exp_pc, ~exp_pc);
                end
            end
            cycle_begin();
        end
    endtask

    // Stall cycles 6..15: buffer fills, requests stop once credit is used up,
    // head is held, and the stream resumes in order on release.
    task automatic test_stall();
        logic [31:0] exp_pc;
        mem_lat = 1;
        do_reset();
        for (int c = 1; c <= 25; c++) begin
            stall_i = (c >= 6 && c <= 15);
            @(negedge clk);
            if (c >= 6 && c <= 15) begin
                exp_pc = RST_PC + 32'd12;
                tests_run++;
                if ({valid_o, pc_o} !== {1'b1, exp_pc}) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_hold c%0d: got valid=%b pc=%h expected valid=1 pc=%h",
                             c, valid_o, pc_o, exp_pc);
                end
                tests_run++;
                if (imem_req_o !== (c < 8)) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_req c%0d: got %b expected %b", c, imem_req_o, (c < 8));
                end
            end else if (c >= 16) begin
                exp_pc = RST_PC + 32'd12 + 32'(4 * (c - 16));
                tests_run++;
                if ({valid_o, pc_o, instruction_o} !== {1'b1, exp_pc, ~exp_pc}) begin
                    tests_failed++;
                    $display("[TB] FAIL stall_resume c%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                             c, valid_o, pc_o, instruction_o, exp_pc, ~exp_pc);
                end
            end
            cycle_begin();
        end
        stall_i = 1'b0;
    endtask

    // 3-cycle memory, redirect to 0x100 in cycle 3 with two requests in
    // flight: both stale words are dropped, first valid shows 0x100.
    task automatic test_flush_latency();
        logic [31:0] exp_pc;
        mem_lat = 3;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            flush_i       = (c == 3);
            redirect_pc_i = 32'h0000_0100;
            @(negedge clk);
            if (c == 3) begin
                tests_run++;
                if (imem_req_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL flush_req_blocked: got %b expected 0", imem_req_o);
                end
            end else if (c == 4) begin
                tests_run++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0000_0100}) begin
                    tests_failed++;
                    $display("[TB] FAIL flush_redirect_req: got req=%b addr=%h expected req=1 addr=00000100",
                             imem_req_o, imem_addr_o);
                end
            end
            if (c >= 4 && c <= 7) begin
                tests_run++;
                if (valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL flush_stale_dropped c%0d: got valid=%b pc=%h expected valid=0",
                             c, valid_o, pc_o);
                end
            end else if (c >= 8) begin
                exp_pc = 32'h0000_0100 + 32'(4 * (c - 8));
                tests_run++;
                if ({valid_o, pc_o, instruction_o} !== {1'b1, exp_pc, ~exp_pc}) begin
                    tests_failed++;
                    $display("[TB] FAIL flush_new_stream c%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                             c, valid_o, pc_o, instruction_o, exp_pc, ~exp_pc);
                end
            end
            cycle_begin();
        end
        flush_i = 1'b0;
        mem_lat = 1;
    endtask

    // Grant withheld in cycles 3..7: address stays put, no PC is skipped.
    task automatic test_gnt_hold();
        logic [31:0] exp_pc;
        mem_lat = 1;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            imem_gnt_i = !(c >= 3 && c <= 7);
            @(negedge clk);
            if (c >= 3 && c <= 8) begin
                tests_run++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, RST_PC + 32'd8}) begin
                    tests_failed++;
                    $display("[TB] FAIL gnt_hold_addr c%0d: got req=%b addr=%h expected req=1 addr=%h",
                             c, imem_req_o, imem_addr_o, RST_PC + 32'd8);
                end
            end
            if (c == 4) begin
                tests_run++;
                if ({valid_o, pc_o} !== {1'b1, RST_PC + 32'd4}) begin
                    tests_failed++;
                    $display("[TB] FAIL gnt_hold_head c4: got valid=%b pc=%h expected valid=1 pc=%h",
                             valid_o, pc_o, RST_PC + 32'd4);
                end
            end else if ((c >= 5 && c <= 7) || c == 9) begin
                tests_run++;
                if (valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL gnt_hold_empty c%0d: got valid=%b expected 0", c, valid_o);
                end
            end else if (c >= 10) begin
                exp_pc = RST_PC + 32'd8 + 32'(4 * (c - 10));
                tests_run++;
                if ({valid_o, pc_o, instruction_o} !== {1'b1, exp_pc, ~exp_pc}) begin
                    tests_failed++;
                    $display("[TB] FAIL gnt_hold_resume c%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                             c, valid_o, pc_o, instruction_o, exp_pc, ~exp_pc);
                end
            end
            cycle_begin();
        end
        imem_gnt_i = 1'b1;
    endtask

    // Flush in cycle 5 while a response arrives and the head is popped;
    // misaligned redirect 0x203 must fetch from 0x200.
    task automatic test_flush_collide();
        logic [31:0] exp_pc;
        mem_lat = 1;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            flush_i       = (c == 5);
            redirect_pc_i = 32'h0000_0203;
            @(negedge clk);
            if (c == 5) begin
                tests_run++;
                if ({valid_o, pc_o, imem_req_o} !== {1'b1, RST_PC + 32'd8, 1'b0}) begin
                    tests_failed++;
                    $display("[TB] FAIL collide_flush_cycle: got valid=%b pc=%h req=%b expected valid=1 pc=%h req=0",
                             valid_o, pc_o, imem_req_o, RST_PC + 32'd8);
                end
            end else if (c == 6) begin
                tests_run++;
                if ({valid_o, instruction_o, pc_o} !== {1'b0, NOP, 32'h0}) begin
                    tests_failed++;
                    $display("[TB] FAIL collide_empty: got valid=%b instr=%h pc=%h expected valid=0 instr=%h pc=0",
                             valid_o, instruction_o, pc_o, NOP);
                end
                tests_run++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, 32'h0000_0200}) begin
                    tests_failed++;
                    $display("[TB] FAIL collide_redirect_req: got req=%b addr=%h expected req=1 addr=00000200",
                             imem_req_o, imem_addr_o);
                end
            end else if (c == 7) begin
                tests_run++;
                if (valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL collide_c7_empty: got valid=%b pc=%h expected valid=0", valid_o, pc_o);
                end
            end else if (c >= 8) begin
                exp_pc = 32'h0000_0200 + 32'(4 * (c - 8));
                tests_run++;
                if ({valid_o, pc_o, instruction_o} !== {1'b1, exp_pc, ~exp_pc}) begin
                    tests_failed++;
                    $display("[TB] FAIL collide_new_stream c%0d: got valid=%b pc=%h instr=%h expected valid=1 pc=%h instr=%h",
                             c, valid_o, pc_o, instruction_o, exp_pc, ~exp_pc);
                end
            end
            cycle_begin();
        end
        flush_i = 1'b0;
    endtask

    // rst pulsed in cycle 5 mid-stream: outputs at reset values in cycle 6
    // and fetching restarts at RESET_PC.
    task automatic test_reset_midstream();
        mem_lat = 1;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            rst = (c == 5);
            @(negedge clk);
            if (c == 4) begin
                tests_run++;
                if ({valid_o, pc_o} !== {1'b1, RST_PC + 32'd4}) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_before: got valid=%b pc=%h expected valid=1 pc=%h",
                             valid_o, pc_o, RST_PC + 32'd4);
                end
            end else if (c == 5) begin
                tests_run++;
                if (imem_req_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_req_in_reset: got %b expected 0", imem_req_o);
                end
            end else if (c == 6) begin
                tests_run++;
                if ({valid_o, instruction_o, pc_o} !== {1'b0, NOP, 32'h0}) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_outputs: got valid=%b instr=%h pc=%h expected valid=0 instr=%h pc=0",
                             valid_o, instruction_o, pc_o, NOP);
                end
                tests_run++;
                if ({imem_req_o, imem_addr_o} !== {1'b1, RST_PC}) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_first_req: got req=%b addr=%h expected req=1 addr=%h",
                             imem_req_o, imem_addr_o, RST_PC);
                end
            end else if (c == 7) begin
                tests_run++;
                if (valid_o !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_c7_empty: got valid=%b pc=%h expected valid=0", valid_o, pc_o);
                end
            end else if (c >= 8) begin
                tests_run++;
                if ({valid_o, pc_o} !== {1'b1, RST_PC + 32'(4 * (c - 8))}) begin
                    tests_failed++;
                    $display("[TB] FAIL midrst_restart c%0d: got valid=%b pc=%h expected valid=1 pc=%h",
                             c, valid_o, pc_o, RST_PC + 32'(4 * (c - 8)));
                end
            end
            cycle_begin();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        redirect_pc_i = 32'h0;
        imem_gnt_i    = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_flush_latency();
        test_gnt_hold();
        test_flush_collide();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
